// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with a registered-ready
// two-entry skid buffer (main register M drives the outputs, skid register S
// absorbs one beat of backpressure).
// Optional feature: define IMM_GEN_ZICSR_EN to decode CSR immediate forms
// (SYSTEM funct3 101/110/111) as zimm with format code 6.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt_out,
  output logic             illegal_out,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6
  } fmt_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;
  logic [2:0]       funct3;

  logic             m_valid, s_valid, s_valid_nxt, rdy_q;
  logic [XLEN-1:0]  m_imm, s_imm;
  fmt_e             m_fmt, s_fmt;
  logic             m_ill, s_ill;
  logic [TAG_W-1:0] m_tag, s_tag;
  logic             accept, drain;

  assign funct3 = in_instr[14:12];
  assign accept = in_valid && rdy_q;
  assign drain  = m_valid && out_ready;

  // Decode the incoming instruction; the sign fill is laid down first and the
  // low field bits overwritten, which keeps every format width-agnostic.
  always_comb begin
    dec_imm = '0;
    dec_fmt = FMT_R;
    dec_ill = 1'b0;
    case (in_instr[6:0])
      OPC_OP: ;
      OPC_OPIMM: begin
        dec_fmt = FMT_I;
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_imm[4:0] = in_instr[24:20];
          if (XLEN == 64) dec_imm[5] = in_instr[25];
        end else begin
          dec_imm        = {XLEN{in_instr[31]}};
          dec_imm[11:0]  = in_instr[31:20];
        end
      end
      OPC_LOAD, OPC_JALR: begin
        dec_fmt       = FMT_I;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = in_instr[31:20];
      end
      OPC_SYSTEM: begin
`ifdef IMM_GEN_ZICSR_EN
        if (funct3 == 3'b101 || funct3 == 3'b110 || funct3 == 3'b111) begin
          dec_fmt      = FMT_Z;
          dec_imm[4:0] = in_instr[19:15];
        end else begin
          dec_fmt       = FMT_I;
          dec_imm       = {XLEN{in_instr[31]}};
          dec_imm[11:0] = in_instr[31:20];
        end
`else
        dec_fmt       = FMT_I;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = in_instr[31:20];
`endif
      end
      OPC_STORE: begin
        dec_fmt       = FMT_S;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[11:0] = {in_instr[31:25], in_instr[11:7]};
      end
      OPC_BRANCH: begin
        dec_fmt       = FMT_B;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[12:0] = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        dec_fmt       = FMT_U;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[31:0] = {in_instr[31:12], 12'h000};
      end
      OPC_JAL: begin
        dec_fmt       = FMT_J;
        dec_imm       = {XLEN{in_instr[31]}};
        dec_imm[20:0] = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // Skid occupancy: S fills only when M is held, and empties into M on a drain.
  // S is never full while M is empty, so S-full implies in_ready low.
  always_comb begin
    s_valid_nxt = s_valid;
    if (accept && m_valid && !drain) s_valid_nxt = 1'b1;
    else if (drain)                  s_valid_nxt = 1'b0;
  end

  // Main register: refill from S first (older entry), else from the input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      m_imm   <= '0;
      m_fmt   <= FMT_R;
      m_ill   <= 1'b0;
      m_tag   <= '0;
    end else if (drain || !m_valid) begin
      if (s_valid) begin
        m_valid <= 1'b1;
        m_imm   <= s_imm;
        m_fmt   <= s_fmt;
        m_ill   <= s_ill;
        m_tag   <= s_tag;
      end else if (accept) begin
        m_valid <= 1'b1;
        m_imm   <= dec_imm;
        m_fmt   <= dec_fmt;
        m_ill   <= dec_ill;
        m_tag   <= in_tag;
      end else begin
        m_valid <= 1'b0;
      end
    end
  end

  // Skid register and the registered ready derived from next S occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_valid <= 1'b0;
      s_imm   <= '0;
      s_fmt   <= FMT_R;
      s_ill   <= 1'b0;
      s_tag   <= '0;
      rdy_q   <= 1'b1;
    end else begin
      s_valid <= s_valid_nxt;
      rdy_q   <= !s_valid_nxt;
      if (accept && m_valid && !drain) begin
        s_imm <= dec_imm;
        s_fmt <= dec_fmt;
        s_ill <= dec_ill;
        s_tag <= in_tag;
      end
    end
  end

  assign in_ready    = rdy_q;
  assign out_valid   = m_valid;
  assign imm_out     = m_imm;
  assign fmt_out     = m_fmt;
  assign illegal_out = m_ill;
  assign tag_out     = m_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one input
// stream; a scoreboard queue holds the expected bundle for each accepted
// instruction and a negedge monitor pops and compares it on every transfer.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_tag = '0;
  logic        out_ready = 1'b0;

  logic        rdy32, ov32, ill32, rdy64, ov64, ill64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0]  fmt32, fmt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready),
    .imm_out(imm32), .fmt_out(fmt32), .illegal_out(ill32), .tag_out(tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready),
    .imm_out(imm64), .fmt_out(fmt64), .illegal_out(ill64), .tag_out(tag64)
  );

  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference decode built from arithmetic shifts of the sign-extended word.
  function automatic void model(input logic [31:0] i, output logic [31:0] e32,
                                output logic [63:0] e64, output logic [2:0] f,
                                output logic ill);
    longint s, hi;
    logic [63:0] v;
    s = $signed(i);
    hi = s >>> 31;
    v = '0; f = 3'd0; ill = 1'b0;
    case (i[6:0])
      7'h33: ;
      7'h13: begin
        f = 3'd1;
        if (i[13:12] == 2'b01) begin
          e64 = {58'd0, i[25:20]};
          e32 = {27'd0, i[24:20]};
          return;
        end
        v = s >>> 20;
      end
      7'h03, 7'h67: begin f = 3'd1; v = s >>> 20; end
      7'h73: begin
        f = 3'd1; v = s >>> 20;
`ifdef IMM_GEN_ZICSR_EN
        if (i[14] && i[13:12] != 2'b00) begin f = 3'd6; v = {59'd0, i[19:15]}; end
`endif
      end
      7'h23: begin
        f = 3'd2; hi = s >>> 25;
        v = (hi << 5) | {59'd0, i[11:7]};
      end
      7'h63: begin
        f = 3'd3;
        v = (hi << 12) | ({63'd0, i[7]} << 11) | ({58'd0, i[30:25]} << 5) | ({60'd0, i[11:8]} << 1);
      end
      7'h37, 7'h17: begin f = 3'd4; v = s & 64'hFFFF_FFFF_FFFF_F000; end
      7'h6F: begin
        f = 3'd5;
        v = (hi << 20) | ({56'd0, i[19:12]} << 12) | ({63'd0, i[20]} << 11) | ({54'd0, i[30:21]} << 1);
      end
      default: ill = 1'b1;
    endcase
    e64 = v;
    e32 = v[31:0];
  endfunction

  // Scoreboard monitor: sample away from the active edge, pop on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (rdy32 !== rdy64 || ov32 !== ov64) begin
        errors++;
        $display("FAIL width_lockstep rdy32=%b rdy64=%b ov32=%b ov64=%b", rdy32, rdy64, ov32, ov64);
      end
      if (ov32 === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output tag=%h imm=%h", tag32, imm32);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (imm32 !== e.e32 || fmt32 !== e.fmt || ill32 !== e.ill || tag32 !== e.tag) begin
            errors++;
            $display("FAIL out32 got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     imm32, fmt32, ill32, tag32, e.e32, e.fmt, e.ill, e.tag);
          end
          if (ov64 !== 1'b1 || imm64 !== e.e64 || fmt64 !== e.fmt || ill64 !== e.ill || tag64 !== e.tag) begin
            errors++;
            $display("FAIL out64 got imm=%h fmt=%0d ill=%b tag=%h want imm=%h fmt=%0d ill=%b tag=%h",
                     imm64, fmt64, ill64, tag64, e.e64, e.fmt, e.ill, e.tag);
          end
          if (e.lat && cyc != e.acc + 1) begin
            errors++;
            $display("FAIL latency tag=%h got %0d cycles want 1", e.tag, cyc - e.acc);
          end
        end
      end
    end
  end

  // Present one instruction and hold it until accepted; pushes its expectation.
  task automatic send_exp(input logic [31:0] instr, input logic [31:0] tag, input bit lat,
                          input logic [31:0] e32, input logic [63:0] e64,
                          input logic [2:0] fmt, input logic ill);
    exp_t e;
    bit got;
    e.e32 = e32; e.e64 = e64; e.fmt = fmt; e.ill = ill; e.tag = tag; e.lat = lat; e.acc = 0;
    in_valid = 1'b1; in_instr = instr; in_tag = tag;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (rdy32 === 1'b1) begin
        e.acc = cyc;
        sb.push_back(e);
        got = 1'b1;
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout tag=%h in_ready=%b want 1", tag, rdy32);
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [31:0] tag, input bit lat);
    logic [31:0] e32; logic [63:0] e64; logic [2:0] f; logic ill;
    model(instr, e32, e64, f, ill);
    send_exp(instr, tag, lat, e32, e64, f, ill);
  endtask

  task automatic wait_drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && ov32 === 1'b0) break;
    end
    checks++;
    if (sb.size() != 0 || ov32 !== 1'b0) begin
      errors++;
      $display("FAIL drain pending=%0d out_valid=%b want 0 and 0", sb.size(), ov32);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || imm32 !== 32'd0 || fmt32 !== 3'd0 || ill32 !== 1'b0 || tag32 !== 32'd0 ||
        ov64 !== 1'b0 || rdy64 !== 1'b1 || imm64 !== 64'd0 || fmt64 !== 3'd0 || ill64 !== 1'b0 || tag64 !== 32'd0) begin
      errors++;
      $display("FAIL reset_values ov=%b rdy=%b imm=%h fmt=%0d ill=%b tag=%h want 0 1 0 0 0 0",
               ov32, rdy32, imm32, fmt32, ill32, tag32);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_exp(32'hFFF00093, 32'd0, 1'b1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0);
    send_exp(32'h123450B7, 32'd1, 1'b1, 32'h12345000, 64'h00000000_12345000, 3'd4, 1'b0);
    send_exp(32'hFE000EE3, 32'd2, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0);
    send_exp(32'h4030D093, 32'd3, 1'b1, 32'h00000003, 64'h00000000_00000003, 3'd1, 1'b0);
    wait_drain();
  endtask

  task automatic test_xlen64();
    out_ready = 1'b1;
    send_exp(32'h80000037, 32'h10, 1'b1, 32'h80000000, 64'hFFFFFFFF_80000000, 3'd4, 1'b0);
    send_exp(32'h03F09093, 32'h11, 1'b1, 32'h0000001F, 64'h00000000_0000003F, 3'd1, 1'b0);
    send_exp(32'hFE112E23, 32'h12, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0);
    send_exp(32'hFFDFF0EF, 32'h13, 1'b1, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC, 3'd5, 1'b0);
    wait_drain();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    send_exp(32'h0000007F, 32'h20, 1'b1, 32'd0, 64'd0, 3'd0, 1'b1);
    wait_drain();
  endtask

  task automatic test_zicsr();
    out_ready = 1'b1;
`ifdef IMM_GEN_ZICSR_EN
    send_exp(32'h3002D073, 32'h30, 1'b1, 32'h00000005, 64'h5, 3'd6, 1'b0);
`else
    send_exp(32'h3002D073, 32'h30, 1'b1, 32'h00000300, 64'h300, 3'd1, 1'b0);
`endif
    send_exp(32'h30001073, 32'h31, 1'b1, 32'h00000300, 64'h300, 3'd1, 1'b0);
    wait_drain();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(32'h00A00093, 32'hA, 1'b0);
    send(32'h00B00113, 32'hB, 1'b0);
    checks++;
    if (rdy32 !== 1'b0 || ov32 !== 1'b1 || tag32 !== 32'hA) begin
      errors++;
      $display("FAIL bp_full in_ready=%b out_valid=%b tag=%h want 0 1 0000000a", rdy32, ov32, tag32);
    end
    in_valid = 1'b1; in_instr = 32'h00C00193; in_tag = 32'hC;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checks++;
      if (rdy32 !== 1'b0 || ov32 !== 1'b1 || tag32 !== 32'hA || imm32 !== 32'hA) begin
        errors++;
        $display("FAIL bp_hold in_ready=%b out_valid=%b tag=%h imm=%h want 0 1 a a", rdy32, ov32, tag32, imm32);
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b1 || tag32 !== 32'hB) begin
      errors++;
      $display("FAIL bp_second out_valid=%b tag=%h want 1 0000000b", ov32, tag32);
    end
    send(32'h00C00193, 32'hC, 1'b1);
    checks++;
    if (ov32 !== 1'b1 || tag32 !== 32'hC) begin
      errors++;
      $display("FAIL bp_third out_valid=%b tag=%h want 1 0000000c", ov32, tag32);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_dup out_valid=%b want 0", ov32);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h00100093, 32'h40, 1'b0);
    send(32'h00200113, 32'h41, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ov32 !== 1'b0 || rdy32 !== 1'b1 || ov64 !== 1'b0 || rdy64 !== 1'b1) begin
      errors++;
      $display("FAIL async_reset out_valid=%b in_ready=%b want 0 1", ov32, rdy32);
    end
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(32'h00300193, 32'h42, 1'b1);
    wait_drain();
  endtask

  task automatic test_random();
    logic [6:0] ops [0:10];
    bit done;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h67; ops[4] = 7'h73;
    ops[5] = 7'h23; ops[6] = 7'h63; ops[7] = 7'h37; ops[8] = 7'h17; ops[9] = 7'h6F;
    ops[10] = 7'h5B;
    done = 1'b0;
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          logic [31:0] ins;
          ins = $urandom();
          ins[6:0] = ops[$urandom_range(0, 10)];
          send(ins, 32'h100 + n, 1'b0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_xlen64();
    test_illegal();
    test_zicsr();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
